// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the set-associative cache.
package cache_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    WR_REQ,
    WR_WAIT,
    RESP,
    INVAL
  } cache_state_e;

  // Byte-offset width inside one line.
  function automatic int offw(input int blocksz);
    return $clog2(blocksz / 8);
  endfunction

  // Set-index width.
  function automatic int idxw(input int numsets);
    return $clog2(numsets);
  endfunction

  // Tag width: whatever address bits remain above index and offset.
  function automatic int tagw(input int addrsz, input int numsets, input int blocksz);
    return addrsz - idxw(numsets) - offw(blocksz);
  endfunction

  // Index of the WIDTH-bit word inside its line that a byte address selects.
  function automatic int unsigned word_sel(input logic [63:0] addr,
                                           input int unsigned width,
                                           input int unsigned blocksz);
    return 32'((addr / 64'(width / 8)) % 64'(blocksz / width));
  endfunction

endpackage

// File: rtl/cache_sa_if.sv
// Core request/response port and block-memory port of the cache.
interface cache_sa_if #(
  parameter int ADDRESSSIZE = 64,
  parameter int WIDTH       = 64,
  parameter int BLOCKSZ     = 512
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_wr;
  logic [ADDRESSSIZE-1:0] req_addr;
  logic [WIDTH-1:0]       req_wdata;
  logic                   resp_valid;
  logic [WIDTH-1:0]       resp_rdata;
  logic                   inv;
  logic                   mem_req;
  logic                   mem_wr_en;
  logic [ADDRESSSIZE-1:0] mem_address;
  logic [WIDTH-1:0]       mem_data_out;
  logic [BLOCKSZ-1:0]     mem_data_in;
  logic                   mem_data_valid;

  // Cache side.
  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, inv, mem_data_in, mem_data_valid,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_wr_en, mem_address, mem_data_out
  );

  // Core + memory side.
  modport master (
    output req_valid, req_wr, req_addr, req_wdata, inv, mem_data_in, mem_data_valid,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_wr_en, mem_address, mem_data_out
  );
endinterface

// File: rtl/cache_way.sv
// One way of the cache: per-set line data, tag and valid bit with a
// combinational read port, full-line fill, single-word write and bulk clear.
module cache_way
  import cache_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int BLOCKSZ = 512,
  parameter int NUMSETS = 256,
  parameter int TAGW    = 50
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [idxw(NUMSETS)-1:0]    idx_i,
  output logic                        valid_o,
  output logic [TAGW-1:0]             tag_o,
  output logic [BLOCKSZ-1:0]          line_o,
  input  logic                        fill_en_i,
  input  logic [TAGW-1:0]             fill_tag_i,
  input  logic [BLOCKSZ-1:0]          fill_line_i,
  input  logic                        wr_en_i,
  input  logic [((BLOCKSZ/WIDTH) > 1 ? $clog2(BLOCKSZ/WIDTH) : 1)-1:0] wr_sel_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic                        clr_i
);
  localparam int WPB   = BLOCKSZ / WIDTH;
  localparam int WSELW = (WPB > 1) ? $clog2(WPB) : 1;

  logic [NUMSETS-1:0] valid_q;
  logic [TAGW-1:0]    tag_q [NUMSETS];

  // Valid bits: cleared by reset or bulk invalidate, set by a fill.
  always_ff @(posedge clk) begin
    if (rst || clr_i) valid_q <= '0;
    else if (fill_en_i) valid_q[idx_i] <= 1'b1;
  end

  // Tags are only written on fill; no reset needed.
  always_ff @(posedge clk) begin
    if (fill_en_i) tag_q[idx_i] <= fill_tag_i;
  end

  assign valid_o = valid_q[idx_i];
  assign tag_o   = tag_q[idx_i];

  // Data is banked per word so a store hit touches only its own bank.
  for (genvar w = 0; w < WPB; w++) begin : g_word
    logic [WIDTH-1:0] data_q [NUMSETS];

    // Fill writes every bank; a store hit writes the selected bank only.
    always_ff @(posedge clk) begin
      if (fill_en_i) data_q[idx_i] <= fill_line_i[w*WIDTH +: WIDTH];
      else if (wr_en_i && (wr_sel_i == WSELW'(w))) data_q[idx_i] <= wr_data_i;
    end

    assign line_o[w*WIDTH +: WIDTH] = data_q[idx_i];
  end
endmodule

// File: rtl/cache_sa.sv
// Blocking N-way set-associative write-through, no-write-allocate data cache.
//
//   state     | meaning
//   IDLE      | ready for a request or an invalidate
//   LOOKUP    | tag compare; store hit updates the array here
//   MISS_REQ  | one-cycle line fetch request
//   MISS_WAIT | waiting for fill data
//   FILL      | write line into victim way, bump round-robin pointer
//   WR_REQ    | one-cycle write-through request
//   WR_WAIT   | waiting for write acknowledge
//   RESP      | one-cycle response pulse
//   INVAL     | clear all valid bits and victim pointers
module cache_sa
  import cache_pkg::*;
#(
  parameter int ADDRESSSIZE = 64,
  parameter int WIDTH       = 64,
  parameter int BLOCKSZ     = 512,
  parameter int NUMSETS     = 256,
  parameter int WAYS        = 2
) (
  input logic       clk,
  input logic       rst,
  cache_sa_if.slave bus
);
  localparam int OFFW  = offw(BLOCKSZ);
  localparam int IDXW  = idxw(NUMSETS);
  localparam int TAGW  = tagw(ADDRESSSIZE, NUMSETS, BLOCKSZ);
  localparam int WPB   = BLOCKSZ / WIDTH;
  localparam int WSELW = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  cache_state_e state_q, state_d;

  logic                   wr_q;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [WIDTH-1:0]       wdata_q;
  logic [BLOCKSZ-1:0]     fill_q;
  logic [WIDTH-1:0]       rdata_q;
  logic [ADDRESSSIZE-1:0] mem_address_q;
  logic [WIDTH-1:0]       mem_data_out_q;
  logic [WAYW-1:0]        vptr_q [NUMSETS];

  logic [IDXW-1:0]        idx;
  logic [TAGW-1:0]        tag;
  logic [WSELW-1:0]       wsel;
  logic [ADDRESSSIZE-1:0] line_addr;
  logic [WAYW-1:0]        vptr_nxt;

  logic [WAYS-1:0]        way_valid;
  logic [TAGW-1:0]        way_tag  [WAYS];
  logic [BLOCKSZ-1:0]     way_line [WAYS];
  logic [WAYS-1:0]        hit;
  logic                   hit_any;
  logic [BLOCKSZ-1:0]     hit_line;
  logic [WIDTH-1:0]       hit_words  [WPB];
  logic [WIDTH-1:0]       fill_words [WPB];

  logic ready_c, resp_valid_c, mem_req_c, mem_wr_c, accept;

  assign idx       = addr_q[OFFW +: IDXW];
  assign tag       = addr_q[ADDRESSSIZE-1 -: TAGW];
  assign wsel      = WSELW'(word_sel(64'(addr_q), WIDTH, BLOCKSZ));
  assign line_addr = {addr_q[ADDRESSSIZE-1:OFFW], {OFFW{1'b0}}};
  assign vptr_nxt  = (vptr_q[idx] == WAYW'(WAYS - 1)) ? '0 : vptr_q[idx] + 1'b1;
  assign accept    = (state_q == IDLE) && !bus.inv && bus.req_valid;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(
      .WIDTH  (WIDTH),
      .BLOCKSZ(BLOCKSZ),
      .NUMSETS(NUMSETS),
      .TAGW   (TAGW)
    ) u_way (
      .clk        (clk),
      .rst        (rst),
      .idx_i      (idx),
      .valid_o    (way_valid[g]),
      .tag_o      (way_tag[g]),
      .line_o     (way_line[g]),
      .fill_en_i  ((state_q == FILL) && (vptr_q[idx] == WAYW'(g))),
      .fill_tag_i (tag),
      .fill_line_i(fill_q),
      .wr_en_i    ((state_q == LOOKUP) && wr_q && hit[g]),
      .wr_sel_i   (wsel),
      .wr_data_i  (wdata_q),
      .clr_i      (state_q == INVAL)
    );
    assign hit[g] = way_valid[g] && (way_tag[g] == tag);
  end

  // At most one way can hit, so an OR-style priority pick is exact.
  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit[w]) hit_line = way_line[w];
    end
  end
  assign hit_any = |hit;

  for (genvar w = 0; w < WPB; w++) begin : g_split
    assign hit_words[w]  = hit_line[w*WIDTH +: WIDTH];
    assign fill_words[w] = fill_q[w*WIDTH +: WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end

  // Next-state logic; invalidate wins over a pending request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.inv) state_d = INVAL;
                 else if (bus.req_valid) state_d = LOOKUP;
      LOOKUP:    if (wr_q) state_d = WR_REQ;
                 else if (hit_any) state_d = RESP;
                 else state_d = MISS_REQ;
      MISS_REQ:  state_d = MISS_WAIT;
      MISS_WAIT: if (bus.mem_data_valid) state_d = FILL;
      FILL:      state_d = RESP;
      WR_REQ:    state_d = WR_WAIT;
      WR_WAIT:   if (bus.mem_data_valid) state_d = RESP;
      RESP:      state_d = IDLE;
      INVAL:     state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    ready_c      = (state_q == IDLE) && !bus.inv;
    resp_valid_c = (state_q == RESP);
    mem_req_c    = (state_q == MISS_REQ) || (state_q == WR_REQ);
    mem_wr_c     = (state_q == WR_REQ);
  end

  // Request capture and fill-data latch; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q    <= bus.req_wr;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
    if ((state_q == MISS_WAIT) && bus.mem_data_valid) fill_q <= bus.mem_data_in;
  end

  // Response data, memory-port holding registers and round-robin pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q        <= '0;
      mem_address_q  <= '0;
      mem_data_out_q <= '0;
      for (int s = 0; s < NUMSETS; s++) vptr_q[s] <= '0;
    end else begin
      case (state_q)
        LOOKUP: begin
          if (wr_q) begin
            mem_address_q  <= addr_q;
            mem_data_out_q <= wdata_q;
          end else if (hit_any) begin
            rdata_q <= hit_words[wsel];
          end else begin
            mem_address_q <= line_addr;
          end
        end
        FILL: begin
          vptr_q[idx] <= vptr_nxt;
          rdata_q     <= fill_words[wsel];
        end
        WR_WAIT: if (bus.mem_data_valid) rdata_q <= '0;
        INVAL:   for (int s = 0; s < NUMSETS; s++) vptr_q[s] <= '0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = ready_c;
  assign bus.resp_valid   = resp_valid_c;
  assign bus.resp_rdata   = rdata_q;
  assign bus.mem_req      = mem_req_c;
  assign bus.mem_wr_en    = mem_wr_c;
  assign bus.mem_address  = mem_address_q;
  assign bus.mem_data_out = mem_data_out_q;
endmodule
